gan_frame_serializer: RTL and testbench
=======================================

Name: gan_frame_serializer

Overview:
- Transmit-side counterpart of the serial pixel ingress on gan_serial_top.
- Captures one generated frame (PIXELS signed words, flat bus) and streams it out one bit per handshake over valid/ready.
- Default mode binarizes each pixel, so the output stream has exactly the 784-bit format gan_serial_top accepts and can loop back into it.

Parameters:
- PIXELS, 784, pixels per frame.
- PIXEL_WIDTH, 16, signed bits per pixel in frame_flat.
- THRESHOLD, 0, signed value; a pixel strictly greater than THRESHOLD emits 1, otherwise 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_flat  input  PIXELS*PIXEL_WIDTH  generated frame; pixel i = frame_flat[i*PIXEL_WIDTH +: PIXEL_WIDTH].
- frame_valid  input  1  frame_flat valid (connects to generated_frame_valid).
- frame_ready  output  1  block can accept a frame.
- bit_out  output  1  serialized data bit.
- bit_valid  output  1  bit_out valid.
- bit_ready  input  1  sink accepts bit_out this cycle.
- busy  output  1  frame captured and not yet fully sent.
- frame_done  output  1  one-cycle pulse after the last bit handshake.
- overrun  output  1  sticky; a frame was offered while busy.

Behaviour:
- Reset (async, immediate): state=IDLE, bit_out=0, bit_valid=0, busy=0, frame_done=0, overrun=0, frame_ready=1, bit index=0, frame register cleared.
- States and transitions:
  - IDLE to SEND on frame_valid && frame_ready. frame_flat latches into an internal register, index=0, busy=1.
  - SEND to DONE on the handshake (bit_valid && bit_ready) of the final bit, index = TOTAL_BITS-1.
  - DONE to IDLE unconditionally after 1 cycle. frame_done=1 in DONE only.
- TOTAL_BITS = PIXELS in default mode.
- frame_ready = (state==IDLE), combinational from the state register. A new frame is accepted the cycle after frame_done.
- Latency: frame accepted at edge N; bit_valid=1 with bit for index 0 after edge N (cycle N+1).
- All outputs are registered.
- Bit order: pixel 0 first, ascending pixel index.
- Default bit value: ($signed(pixel) > $signed(THRESHOLD)) ? 1 : 0, a full PIXEL_WIDTH signed compare.
  - pixel == THRESHOLD gives 0.
  - most-negative pixel gives 0.
- Handshake:
  - bit_valid stays high and bit_out stays stable until bit_ready is sampled high.
  - The index advances only on a handshake; one bit transfers per cycle at most.
  - bit_ready held high gives back-to-back bits every cycle, TOTAL_BITS cycles in total.
- bit_valid deasserts on the edge that completes the last handshake and stays 0 in DONE and IDLE. bit_out returns to 0 outside SEND.
- Frames during SEND or DONE:
  - frame_valid is ignored and the captured frame is not disturbed.
  - overrun is set and stays 1 until rst.
  - In IDLE, frame_valid never sets overrun.
- Input timing: frame_flat is sampled only on the accept edge, so later changes do not affect the stream.
- bit_ready while bit_valid=0 has no effect.
- Reset mid-frame aborts the transfer immediately: bit_valid drops, the index clears, no frame_done.
- Index counter width = $clog2(TOTAL_BITS). It never wraps past TOTAL_BITS-1.

Optional Feature:
- Macro: GAN_SERIALIZER_FULL_WORD_EN.
- Defined:
  - TOTAL_BITS = PIXELS*PIXEL_WIDTH; each pixel is sent raw, MSB first, pixel 0 first. Threshold logic is removed.
  - Counters split into a pixel index and a bit index. The bit index runs from PIXEL_WIDTH-1 down to 0, then the pixel index increments.
- Undefined: binarized 1 bit per pixel as above; no full-word logic is synthesized.

Test Plan:
- Reset then idle 5 cycles -> frame_ready=1, bit_valid=0, busy=0, overrun=0, frame_done=0.
- Frame with pixel i = (i%8==0) ? +100 : -100, bit_ready=1 -> 784 consecutive bits, pattern 1,0,0,0,0,0,0,0 repeating, then one frame_done pulse. frame_ready is back to 1 the cycle after the pulse, 786 cycles after accept.
- THRESHOLD=0 with pixels 0, 1, -1, 16'h7FFF, 16'h8000 at indices 0..4 -> bits 0,1,0,1,0.
- bit_ready toggles pseudo-randomly (LFSR) -> bit_out stable whenever bit_valid && !bit_ready, no bits lost or duplicated, 784 handshakes total.
- frame_valid pulsed at bit 300 with a different frame -> stream still matches the first frame, overrun=1 and stays 1 after frame_done. The next frame, offered in IDLE, is accepted normally.
- rst asserted at bit 500, then a new frame sent -> bit_valid drops without a clock edge and no frame_done occurs. After rst release, the new frame streams from bit 0 correctly.
- GAN_SERIALIZER_FULL_WORD_EN defined with pixel 0 = 16'hA5C3 -> first 16 bits are 1010010111000011, 12544 bits total, then frame_done.

Source files
------------

// File: rtl/gan_frame_serializer.sv
// gan_frame_serializer
//   Captures one generated frame and streams it out one bit per valid/ready
//   handshake. Pixel 0 goes first. In the default build each pixel becomes a
//   single bit, 1 when pixel > THRESHOLD (signed). The result is the
//   PIXELS-bit stream that gan_serial_top ingests.
//
//   Optional build macro GAN_SERIALIZER_FULL_WORD_EN: each pixel is sent raw,
//   MSB first, for PIXELS*PIXEL_WIDTH bits per frame. No threshold logic is
//   built in this mode.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   frame_flat   frame, pixel i = frame_flat[i*PIXEL_WIDTH +: PIXEL_WIDTH]
//   frame_valid  frame offered; frame_ready = block is idle and will take it
//   bit_out      serialized bit, qualified by bit_valid, consumed on bit_ready
//   busy         frame captured and not yet fully sent
//   frame_done   one-cycle pulse after the last bit handshake
//   overrun      sticky: a frame was offered while not idle
module gan_frame_serializer #(
    parameter int PIXELS      = 784,
    parameter int PIXEL_WIDTH = 16,
    parameter int THRESHOLD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIXELS*PIXEL_WIDTH-1:0] frame_flat,
    input  logic                          frame_valid,
    output logic                          frame_ready,
    output logic                          bit_out,
    output logic                          bit_valid,
    input  logic                          bit_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state, state_nxt;

    logic accept, hs, last;
    logic first_bit, next_bit;

    assign frame_ready = (state == IDLE);
    assign accept      = frame_valid && (state == IDLE);
    // bit_valid is only ever high in SEND, so hs implies SEND.
    assign hs          = bit_valid && bit_ready;

`ifdef GAN_SERIALIZER_FULL_WORD_EN
    localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int BW = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
    localparam int FW = $clog2(PIXELS*PIXEL_WIDTH);

    logic [PIXELS*PIXEL_WIDTH-1:0] frame_reg;
    logic [PW-1:0]                 pix_idx, pix_nxt;
    logic [BW-1:0]                 bit_idx, bit_nxt;
    logic [FW-1:0]                 pos_nxt;

    assign last = (pix_idx == PW'(PIXELS-1)) && (bit_idx == '0);

    // Bit index walks MSB..LSB within a pixel, then the pixel index steps.
    // Holding at the final position keeps the counters from wrapping.
    always_comb begin
        pix_nxt = pix_idx;
        bit_nxt = bit_idx;
        if (!last) begin
            if (bit_idx == '0) begin
                pix_nxt = pix_idx + 1'b1;
                bit_nxt = BW'(PIXEL_WIDTH-1);
            end else begin
                bit_nxt = bit_idx - 1'b1;
            end
        end
    end

    assign pos_nxt   = FW'(pix_nxt) * FW'(PIXEL_WIDTH) + FW'(bit_nxt);
    assign next_bit  = frame_reg[pos_nxt];
    assign first_bit = frame_flat[PIXEL_WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_reg <= '0;
            pix_idx   <= '0;
            bit_idx   <= '0;
        end else if (accept) begin
            frame_reg <= frame_flat;
            pix_idx   <= '0;
            bit_idx   <= BW'(PIXEL_WIDTH-1);
        end else if (hs) begin
            pix_idx   <= pix_nxt;
            bit_idx   <= bit_nxt;
        end
    end
`else
    localparam int IW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic signed [PIXEL_WIDTH-1:0] THR = PIXEL_WIDTH'(THRESHOLD);

    // Only the thresholded bits are ever sent, so the captured frame is held
    // in its binarized form.
    logic [PIXELS-1:0] bin_in, bin_reg;
    logic [IW-1:0]     idx, idx_nxt;

    for (genvar gi = 0; gi < PIXELS; gi++) begin : g_bin
        assign bin_in[gi] = $signed(frame_flat[gi*PIXEL_WIDTH +: PIXEL_WIDTH]) > THR;
    end

    assign last      = (idx == IW'(PIXELS-1));
    assign idx_nxt   = last ? idx : idx + 1'b1;
    assign next_bit  = bin_reg[idx_nxt];
    assign first_bit = bin_in[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg <= '0;
            idx     <= '0;
        end else if (accept) begin
            bin_reg <= bin_in;
            idx     <= '0;
        end else if (hs) begin
            idx     <= idx_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_valid)  state_nxt = SEND;
            SEND:    if (hs && last)   state_nxt = DONE;
            DONE:                      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Registered outputs; the first bit is loaded on the accept edge so it
    // is presented the cycle right after the frame is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        bit_out   <= first_bit;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (last) begin
                            bit_out    <= 1'b0;
                            bit_valid  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_out    <= next_bit;
                        end
                    end
                end
                default: begin
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gan_frame_serializer.sv
module tb_gan_frame_serializer;

    localparam int PIXELS = 784;
    localparam int PW     = 16;
    localparam int FWB    = PIXELS*PW;
`ifdef GAN_SERIALIZER_FULL_WORD_EN
    localparam int TOTAL  = PIXELS*PW;
`else
    localparam int TOTAL  = PIXELS;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [FWB-1:0] frame_flat;
    logic           frame_valid;
    logic           frame_ready;
    logic           bit_out;
    logic           bit_valid;
    logic           bit_ready;
    logic           busy;
    logic           frame_done;
    logic           overrun;

    gan_frame_serializer dut (
        .clk(clk), .rst(rst), .frame_flat(frame_flat), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [15:0] lfsr = 16'hACE1;

    typedef struct {
        logic [15:0] px;
        logic        exp;
    } vec_t;
    vec_t tbl[8];

    logic [FWB-1:0]   fA, fB, fC, fT;
    logic [TOTAL-1:0] eA, eC, eT, got;
    int hs_cnt, cycles, errs, dn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [FWB-1:0] f);
        frame_flat  = f;
        frame_valid = 1'b1;
        chk("accept_ready", frame_ready, 1);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        frame_flat  = ~f;  // later input changes must not reach the stream
    endtask

    // Called #1 after an edge with a frame in flight. Drives bit_ready and
    // checks every presented bit against expb until stop_at handshakes.
    task automatic stream(input logic [TOTAL-1:0] expb, input bit rnd, input int stop_at,
                          input int pulse_at, input logic [FWB-1:0] alt,
                          output logic [TOTAL-1:0] rx, output int n, output int cyc, output int e);
        logic rdy, held, stall, b, pulsed;
        n = 0; cyc = 0; e = 0; stall = 0; held = 0; pulsed = 0; rx = '0;
        while (n < stop_at && cyc < 4*TOTAL + 64) begin
            rdy  = rnd ? lfsr[0] : 1'b1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (bit_valid !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) e++;
            if (bit_out !== expb[n]) e++;
            if (stall && bit_out !== held) e++;
            stall = !rdy; held = bit_out; b = bit_out;
            if (n == pulse_at && !pulsed) begin
                frame_valid = 1'b1; frame_flat = alt; pulsed = 1'b1;
            end else begin
                frame_valid = 1'b0;
            end
            bit_ready = rdy;
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin rx[n] = b; n++; end
        end
        bit_ready   = 1'b0;
        frame_valid = 1'b0;
    endtask

    // Called #1 after the final handshake edge.
    task automatic post_done(input string nm, input logic exp_ovr);
        chk({nm, "_done_pulse"}, frame_done, 1);
        chk({nm, "_valid_low"},  bit_valid, 0);
        chk({nm, "_bit_zero"},   bit_out, 0);
        chk({nm, "_busy_low"},   busy, 0);
        chk({nm, "_ready_low"},  frame_ready, 0);
        @(posedge clk); #1;
        chk({nm, "_done_off"},   frame_done, 0);
        chk({nm, "_ready_back"}, frame_ready, 1);
        chk({nm, "_overrun"},    overrun, {31'd0, exp_ovr});
    endtask

    initial begin
        rst = 1'b1; frame_flat = '0; frame_valid = 1'b0; bit_ready = 1'b0;

        tbl[0] = '{16'h0000, 1'b0};  // equal to threshold
        tbl[1] = '{16'h0001, 1'b1};
        tbl[2] = '{16'hFFFF, 1'b0};  // -1
        tbl[3] = '{16'h7FFF, 1'b1};  // most positive
        tbl[4] = '{16'h8000, 1'b0};  // most negative
        tbl[5] = '{16'h0064, 1'b1};
        tbl[6] = '{16'hFF9C, 1'b0};
        tbl[7] = '{16'h0002, 1'b1};

        fA = '0; fB = '0; fC = '0; fT = '0; eA = '0; eC = '0; eT = '0;
        for (int i = 0; i < PIXELS; i++) begin
            fA[i*PW +: PW] = (i % 8 == 0) ? 16'd100 : 16'hFF9C;
            fB[i*PW +: PW] = 16'd5;
            fC[i*PW +: PW] = (i % 3 == 0) ? 16'd1 : 16'd0;
            fT[i*PW +: PW] = 16'hFFFF;
        end
        for (int i = 0; i < 8; i++) fT[i*PW +: PW] = tbl[i].px;
        fT[(PIXELS-1)*PW +: PW] = 16'd1;
`ifndef GAN_SERIALIZER_FULL_WORD_EN
        for (int i = 0; i < PIXELS; i++) begin
            eA[i] = (i % 8 == 0);
            eC[i] = (i % 3 == 0);
        end
        for (int i = 0; i < 8; i++) eT[i] = tbl[i].exp;
        eT[PIXELS-1] = 1'b1;
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_frame_ready", frame_ready, 1);
        chk("rst_bit_valid",   bit_valid, 0);
        chk("rst_busy",        busy, 0);
        chk("rst_overrun",     overrun, 0);
        chk("rst_frame_done",  frame_done, 0);

`ifdef GAN_SERIALIZER_FULL_WORD_EN
        fA = '0;
        fA[PW-1:0] = 16'hA5C3;
        eA = '0;
        eA[PW-1:0] = {<<{16'hA5C3}};  // MSB of the pixel is stream bit 0
        accept(fA);
        stream(eA, 1'b0, TOTAL, -1, '0, got, hs_cnt, cycles, errs);
        for (int i = 0; i < PW; i++) chk($sformatf("fw_bit%0d", i), got[i], eA[i]);
        chk("fw_hs_count", hs_cnt, TOTAL);
        chk("fw_stream_errs", errs, 0);
        post_done("fw", 1'b0);
`else
        // Threshold boundary vectors, ready held high
        accept(fT);
        stream(eT, 1'b0, TOTAL, -1, '0, got, hs_cnt, cycles, errs);
        for (int i = 0; i < 8; i++) chk($sformatf("tbl%0d", i), got[i], tbl[i].exp);
        chk("tbl_last_pixel", got[PIXELS-1], 1);
        chk("tbl_stream_errs", errs, 0);
        post_done("tbl", 1'b0);

        // Pattern 1,0,0,0,... back-to-back
        accept(fA);
        stream(eA, 1'b0, TOTAL, -1, '0, got, hs_cnt, cycles, errs);
        chk("pat_cycles", cycles, TOTAL);
        chk("pat_stream_errs", errs, 0);
        chk("pat_bits", (got == eA), 1);
        post_done("pat", 1'b0);

        // Pseudo-random backpressure
        accept(fA);
        stream(eA, 1'b1, TOTAL, -1, '0, got, hs_cnt, cycles, errs);
        chk("bp_hs_count", hs_cnt, TOTAL);
        chk("bp_stream_errs", errs, 0);
        chk("bp_bits", (got == eA), 1);
        post_done("bp", 1'b0);

        // Frame offered mid-stream is dropped and flagged
        accept(fA);
        stream(eA, 1'b0, TOTAL, 300, fB, got, hs_cnt, cycles, errs);
        chk("ovr_stream_errs", errs, 0);
        chk("ovr_bits", (got == eA), 1);
        post_done("ovr", 1'b1);
        accept(fC);
        stream(eC, 1'b0, TOTAL, -1, '0, got, hs_cnt, cycles, errs);
        chk("ovr_next_errs", errs, 0);
        post_done("ovr_next", 1'b1);

        // Reset in the middle of a frame
        accept(fA);
        stream(eA, 1'b0, 500, -1, '0, got, hs_cnt, cycles, errs);
        chk("abort_pre_errs", errs, 0);
        rst = 1'b1;
        #1;
        chk("abort_valid_drop", bit_valid, 0);
        chk("abort_busy_drop",  busy, 0);
        chk("abort_overrun_clr", overrun, 0);
        chk("abort_ready",      frame_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (frame_done !== 1'b0 || bit_valid !== 1'b0) dn++;
        end
        chk("abort_no_done", dn, 0);
        accept(fC);
        stream(eC, 1'b0, TOTAL, -1, '0, got, hs_cnt, cycles, errs);
        chk("abort_next_errs", errs, 0);
        chk("abort_next_bits", (got == eC), 1);
        post_done("abort_next", 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
